// File: rtl/seq_match_scheduler.sv
// seq_match_scheduler
//   Round-robin arbiter in front of one serial pattern matcher shared by NCH
//   byte-stream requesters. A granted byte is shifted MSB-first through the
//   matcher, one bit per clock, using that channel's saved match context so
//   that matches spanning consecutive bytes of the same channel are found.
//
// Ports
//   clock        single clock, rising edge
//   reset_n      asynchronous active-low reset
//   req_valid    [NCH]     channel i has a byte pending
//   req_data     [8*NCH]   byte of channel i in bits [8i+7:8i]
//   req_ready    [NCH]     one-hot accept strobe (combinational, IDLE only)
//   ch_clear     [NCH]     zero history/fill/count of channel i
//   busy                   engine is shifting a byte
//   match_valid            registered one-cycle match pulse
//   match_ch     [clog2]   channel of the match (0 when no match)
//   match_pos    [3]       bit index in the byte, 0 = MSB (0 when no match)
//   cnt_sel      [clog2]   counter select
//   cnt_out      [CNTW]    match count of cnt_sel (combinational read)
module seq_match_scheduler #(
  parameter int              NCH     = 4,
  parameter int              PW      = 5,
  parameter logic [PW-1:0]   PATTERN = 5'b11101,
  parameter int              CNTW    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           req_valid,
  input  logic [8*NCH-1:0]         req_data,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0]           ch_clear,
  output logic                     busy,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch,
  output logic [2:0]               match_pos,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  output logic [CNTW-1:0]          cnt_out
);

  localparam int CHW = $clog2(NCH);
  localparam int HW  = PW - 1;          // history bits kept per channel
  localparam int FW  = $clog2(PW);      // wide enough to hold PW-1
  localparam logic [FW-1:0]   FILL_MAX = FW'(PW - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [CHW-1:0]  act_ch_q, act_ch_d;
  logic [CHW-1:0]  last_grant_q, last_grant_d;
  logic [HW-1:0]   work_hist_q, work_hist_d;
  logic [FW-1:0]   work_fill_q, work_fill_d;
  logic            match_valid_q, match_valid_d;
  logic [CHW-1:0]  match_ch_q, match_ch_d;
  logic [2:0]      match_pos_q, match_pos_d;

  // Per-channel saved context
  logic [HW-1:0]   hist_q [NCH];
  logic [HW-1:0]   hist_d [NCH];
  logic [FW-1:0]   fill_q [NCH];
  logic [FW-1:0]   fill_d [NCH];
  logic [CNTW-1:0] cnt_q  [NCH];
  logic [CNTW-1:0] cnt_d  [NCH];

  // Arbitration
  logic            win_found;
  logic [CHW-1:0]  win_ch;
  logic [7:0]      win_data;

  // Matcher datapath
  logic            bit_in;
  logic [HW-1:0]   shift_hist;
  logic [FW-1:0]   shift_fill;
  logic            hit;
  logic            writeback;

  // First requesting channel after last_grant, wrapping around.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_ch    = '0;
    idx       = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!win_found && req_valid[CHW'(idx)]) begin
        win_found = 1'b1;
        win_ch    = CHW'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win_ch == CHW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // Accept strobe only for the winner while idle; forced low under reset.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ready
      assign req_ready[gi] = reset_n && (state_q == S_IDLE) && win_found &&
                             (win_ch == CHW'(gi));
    end
  endgenerate

  assign bit_in     = shreg_q[7];
  // Keep the newest PW-1 bits: truncation drops the oldest one.
  assign shift_hist = HW'({work_hist_q, bit_in});
  assign shift_fill = (work_fill_q == FILL_MAX) ? FILL_MAX : work_fill_q + 1'b1;

  // FSM next-state and working-register logic
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    act_ch_d      = act_ch_q;
    last_grant_d  = last_grant_q;
    work_hist_d   = work_hist_q;
    work_fill_d   = work_fill_q;
    match_valid_d = 1'b0;
    match_ch_d    = '0;
    match_pos_d   = '0;
    hit           = 1'b0;
    writeback     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          shreg_d      = win_data;
          bitcnt_d     = '0;
          act_ch_d     = win_ch;
          last_grant_d = win_ch;
          state_d      = S_SHIFT;
          // A clear arriving with the grant wins: start from an empty context.
          if (ch_clear[win_ch]) begin
            work_hist_d = '0;
            work_fill_d = '0;
          end else begin
            work_hist_d = hist_q[win_ch];
            work_fill_d = fill_q[win_ch];
          end
        end
      end

      S_SHIFT: begin
        if (ch_clear[act_ch_q]) begin
          // Abort: drop the byte, the slot is zeroed by the context logic.
          state_d = S_IDLE;
        end else begin
          hit           = (work_fill_q == FILL_MAX) && ({work_hist_q, bit_in} == PATTERN);
          work_hist_d   = shift_hist;
          work_fill_d   = shift_fill;
          shreg_d       = {shreg_q[6:0], 1'b0};
          bitcnt_d      = bitcnt_q + 3'd1;
          match_valid_d = hit;
          match_ch_d    = hit ? act_ch_q : '0;
          match_pos_d   = hit ? bitcnt_q : 3'd0;
          if (bitcnt_q == 3'd7) begin
            writeback = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Context slots: counts update on the match edge so cnt_out follows at
  // once; history/fill are written back after the last bit. Clear wins.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hist_d[i] = hist_q[i];
      fill_d[i] = fill_q[i];
      cnt_d[i]  = cnt_q[i];
      if (writeback && (act_ch_q == CHW'(i))) begin
        hist_d[i] = shift_hist;
        fill_d[i] = shift_fill;
      end
      if (hit && (act_ch_q == CHW'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (ch_clear[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      act_ch_q      <= '0;
      last_grant_q  <= CHW'(NCH - 1);
      work_hist_q   <= '0;
      work_fill_q   <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      match_pos_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      act_ch_q      <= act_ch_d;
      last_grant_q  <= last_grant_d;
      work_hist_q   <= work_hist_d;
      work_fill_q   <= work_fill_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      match_pos_q   <= match_pos_d;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_sel == CHW'(i)) cnt_out = cnt_q[i];
    end
  end

  assign busy        = (state_q == S_SHIFT);
  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_pos   = match_pos_q;

endmodule

// File: doc/seq_match_scheduler.md
# seq_match_scheduler

Round-robin scheduler that shares one serial pattern-match engine among NCH byte-stream requesters. It accepts one byte at a time from the granted channel and shifts it MSB-first through the matcher, one bit per clock. Before each byte it restores that channel's saved match context and writes it back afterwards, so overlapping matches that span bytes of the same channel are found. It reports every match with channel and bit position, and keeps a saturating match count per channel.

## Interface
- NCH, 4: number of requesters (2..8)
- PW, 5: pattern width in bits (2..8)
- PATTERN, 5'b11101: pattern to detect; PATTERN[PW-1] is the first bit received
- CNTW, 8: width of each per-channel match counter
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NCH  channel i has a byte pending
- req_data  in  8*NCH  channel i's byte is in bits [8i+7:8i]
- req_ready  out  NCH  one-hot accept strobe; byte i is taken at the edge where valid&ready
- ch_clear  in  NCH  clears the history, fill and count of channel i
- busy  out  1  engine is in SHIFT
- match_valid  out  1  registered one-cycle match pulse
- match_ch  out  clog2(NCH)  channel of the match; 0 when match_valid=0
- match_pos  out  3  bit index within the byte, 0=MSB; 0 when match_valid=0
- cnt_sel  in  clog2(NCH)  selects the counter to read
- cnt_out  out  CNTW  count of cnt_sel, combinational read

## Operation
- Per-channel context:
  - hist: last PW-1 bits received, newest in the LSB
  - fill: bits seen, saturating at PW-1
  - cnt: match count, saturating at 2^CNTW-1
- Pointer last_grant resets to NCH-1, so channel 0 has highest priority after reset.
- IDLE state:
  - The winner is the first channel with req_valid set, searching from last_grant+1 and wrapping.
  - req_ready is asserted combinationally for the winner only. No request means all zero.
  - At the edge: latch the byte into the shift register, load that channel's context into the working registers, set bitcnt=0 and last_grant=winner, and go to SHIFT.
- SHIFT state, one bit b per edge (shift-register MSB):
  - A match occurs if fill==PW-1 and {hist,b}==PATTERN.
  - Working hist becomes {hist[PW-3:0],b} and fill increments (saturating).
  - On a match: the next-cycle match_valid is 1, with match_ch = active channel and match_pos = bitcnt, and cnt increments (saturating).
  - Matches overlap: history is never flushed on a match.
  - After bitcnt==7: write the context back to the channel's slot and go to IDLE.
- ch_clear[i] on an idle channel zeroes hist, fill and cnt at the next edge.
- ch_clear[i] on the active channel aborts the byte: no writeback, no match from that edge's bit, the slot is zeroed, and the FSM returns to IDLE.
- ch_clear has priority over a simultaneous count increment or writeback to the same slot.
- req_valid dropping while a channel is not granted is legal. A byte is never taken without req_ready.

## Timing
- Reset (asynchronous, active-low) drives all outputs to 0: req_ready, busy, match_valid, match_ch, match_pos. All contexts are 0, last_grant=NCH-1, and the FSM is in IDLE.
- cnt_out reads 0 after reset.
- An assertion of reset_n mid-byte discards that byte.
- Accept at edge E0. Bits 0..7 are processed at edges E1..E8. A match on bit k is visible as match_valid in the cycle after edge E(k+1).
- busy is high from E0 to E8. The next accept can occur at edge E9, giving 9 cycles per byte and a peak of 8/9 bit/clk.
- The last match_valid of a byte can overlap the next IDLE cycle.
- cnt_out reflects a count increment in the cycle after the matching edge.

## Test plan
- **Single match:** after reset, ch0 sends 0xE8 -> req_ready[0] for 1 cycle, one match_valid with match_ch=0, match_pos=4, and cnt_out(sel 0)=1.
- **Cross-byte overlap:** ch0 sends 0xEE then 0x80 -> matches at (ch0, pos4) then (ch0, pos0) of the second byte, and cnt=2.
- **Context isolation:** ch0 sends 0x0E, ch1 sends 0xFF, then ch0 sends 0x80 -> exactly one match, ch0 pos0. No match on ch1, and ch1's cnt=0.
- **Round-robin:** all 4 req_valid held high -> grants ch0,1,2,3,0,1 with req_ready pulses exactly 9 cycles apart.
- **Clear mid-byte:** ch2 sends 0xFF and ch_clear[2] is pulsed at bitcnt=3 -> busy drops next cycle, ch2's cnt=0, and ch2's next byte 0x1D (00011101) matches only at pos7.
- **Saturation and reset:** with CNTW=2, ch0 sends 0xE8 four times -> cnt stays 3. Asserting reset_n low mid-byte clears all outputs and counters immediately.
